// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, opcode width and the writeback queue entry.
package pipeline_pkg;

   // Architectural NOP; an empty writeback queue presents this at its head.
   localparam logic [31:0] NOP_INSTR = 32'hE320F000;

   // Width of the opcode field produced by idecoder (instr[27:21]).
   localparam int unsigned OPCODE_W = 7;

   // Widest result data a queue entry can carry; units narrower than this zero-extend.
   localparam int unsigned WB_DATA_W = 64;

   typedef struct packed {
      logic [31:0]          instr;
      logic [WB_DATA_W-1:0] data;
      logic                 wb_en;
   } wb_entry_t;

endpackage

// File: rtl/idecoder.sv
// Minimal instruction decoder: destination register and opcode field.
// The NOP hint has no destination, so it decodes to register 0.
module idecoder
   import pipeline_pkg::*;
(
   input  logic [31:0]         instr,
   output logic [3:0]          rd,
   output logic [OPCODE_W-1:0] opcode
);

   // Decode destination and opcode fields of the instruction word.
   always_comb begin
      opcode = instr[27:21];
      rd     = (instr == NOP_INSTR) ? 4'd0 : instr[15:12];
   end

endmodule

// File: rtl/writeback_queue_unit.sv
// In-order writeback queue feeding the register-file write port.
// Optional decode-stage forwarding outputs are enabled by defining WB_FORWARD_EN.
module writeback_queue_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr_in,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                wb_en_in,
   input  logic                rf_ready,
   output logic                rf_we,
   output logic [3:0]          rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic [3:0]          rt,
   output logic [OPCODE_W-1:0] opcode,
   output logic                empty,
   output logic [CNT_W-1:0]    retire_cnt
`ifdef WB_FORWARD_EN
   ,
   output logic                fwd_valid,
   output logic [3:0]          fwd_reg,
   output logic [DATA_W-1:0]   fwd_data
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_QW = PTR_W + 1;

   wb_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_QW-1:0]  count_q, count_d;
   logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

   wb_entry_t          head;
   wb_entry_t          entry_in;
   logic               push;
   logic               pop;
   logic               unused_head_data;

   // Occupancy flags and handshake; flush suppresses both push and pop.
   always_comb begin
      empty    = (count_q == '0);
      in_ready = (count_q < CNT_QW'(DEPTH));
      push     = in_valid && in_ready && !flush;
      pop      = !empty && (rf_ready || !head.wb_en) && !flush;
   end

   // Head view; an empty queue reads as a non-writing NOP.
   always_comb begin
      if (empty) begin
         head = '{instr: NOP_INSTR, data: '0, wb_en: 1'b0};
      end else begin
         head = mem_q[rd_ptr_q];
      end
      entry_in = '{instr: instr_in, data: WB_DATA_W'(data_in), wb_en: wb_en_in};
   end

   // Register-file write port driven straight from the head entry.
   always_comb begin
      rf_we    = !empty && head.wb_en && rf_ready && !flush;
      rf_waddr = head.instr[15:12];
      rf_wdata = head.data[DATA_W-1:0];
   end

   // Upper data bits beyond DATA_W are always zero and deliberately ignored.
   assign unused_head_data = ^head.data;

   // Next-state for pointers, occupancy and retire counter.
   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      retire_cnt_d = retire_cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_QW'(1);
            2'b01:   count_d = count_q - CNT_QW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         retire_cnt_q <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Entry storage needs no reset: validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry_in;
   end

   assign retire_cnt = retire_cnt_q;

   idecoder u_idecoder (
      .instr  (head.instr),
      .rd     (rt),
      .opcode (opcode)
   );

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the last matching writer wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_valid = 1'b0;
      fwd_reg   = '0;
      fwd_data  = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_QW'(i) < count_q) && mem_q[idx].wb_en) begin
            fwd_valid = 1'b1;
            fwd_reg   = mem_q[idx].instr[15:12];
            fwd_data  = mem_q[idx].data[DATA_W-1:0];
         end
      end
      if (flush) fwd_valid = 1'b0;
   end
`endif

endmodule

// File: tb/tb_writeback_queue_unit.sv
// Self-checking bench for writeback_queue_unit (DEPTH=2, CNT_W=4).
module tb_writeback_queue_unit;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 4;
   localparam logic [6:0]  NOP_OP = 7'h19;
   localparam logic [6:0]  ALU_OP = 7'h04;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       instr_in = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              wb_en_in = 1'b0;
   logic              rf_ready = 1'b0;
   logic              rf_we;
   logic [3:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [3:0]        rt;
   logic [6:0]        opcode;
   logic              empty;
   logic [CNT_W-1:0]  retire_cnt;
`ifdef WB_FORWARD_EN
   logic              fwd_valid;
   logic [3:0]        fwd_reg;
   logic [DATA_W-1:0] fwd_data;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   writeback_queue_unit #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr_in   (instr_in),
      .data_in    (data_in),
      .wb_en_in   (wb_en_in),
      .rf_ready   (rf_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .rt         (rt),
      .opcode     (opcode),
      .empty      (empty),
      .retire_cnt (retire_cnt)
`ifdef WB_FORWARD_EN
      ,
      .fwd_valid  (fwd_valid),
      .fwd_reg    (fwd_reg),
      .fwd_data   (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [3:0]  rd;
      logic [31:0] data;
      logic        wb_en;
      logic        rf_ready;
      logic        e_empty;
      logic        e_in_ready;
      logic        e_we;
      logic [3:0]  e_waddr;
      logic [31:0] e_wdata;
      logic [3:0]  e_rt;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs [15];

   function automatic logic [31:0] mk_instr(input logic [3:0] rd);
      return {4'hE, 4'h0, 4'h8, 4'h0, rd, 12'h000};
   endfunction

   function automatic vec_t mkv(input logic iv, input logic [3:0] rd, input logic [31:0] d,
                                input logic we, input logic rr, input logic ee,
                                input logic eir, input logic ewe, input logic [3:0] ea,
                                input logic [31:0] ed, input logic [3:0] ert,
                                input logic [3:0] ec);
      vec_t v;
      v.in_valid = iv;  v.rd = rd;  v.data = d;  v.wb_en = we;  v.rf_ready = rr;
      v.e_empty = ee;  v.e_in_ready = eir;  v.e_we = ewe;  v.e_waddr = ea;
      v.e_wdata = ed;  v.e_rt = ert;  v.e_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic iv, input logic [3:0] rd, input logic [31:0] d,
                        input logic we, input logic rr, input logic fl);
      in_valid = iv;
      instr_in = mk_instr(rd);
      data_in  = d;
      wb_en_in = we;
      rf_ready = rr;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = mkv(1, 4'd3, 32'hDEAD_BEEF, 1, 1,  1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd0);
      vecs[1]  = mkv(0, 4'd0, 32'h0, 0, 1,          0, 1, 1, 4'd3, 32'hDEAD_BEEF, 4'd3, 4'd0);
      vecs[2]  = mkv(1, 4'd1, 32'h11, 1, 0,         1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd1);
      vecs[3]  = mkv(1, 4'd2, 32'h22, 1, 0,         0, 1, 0, 4'd0, 32'h0, 4'd1, 4'd1);
      vecs[4]  = mkv(1, 4'd4, 32'h33, 1, 0,         0, 0, 0, 4'd0, 32'h0, 4'd1, 4'd1);
      vecs[5]  = mkv(0, 4'd0, 32'h0, 0, 1,          0, 0, 1, 4'd1, 32'h11, 4'd1, 4'd1);
      vecs[6]  = mkv(0, 4'd0, 32'h0, 0, 1,          0, 1, 1, 4'd2, 32'h22, 4'd2, 4'd2);
      vecs[7]  = mkv(0, 4'd0, 32'h0, 0, 1,          1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd3);
      vecs[8]  = mkv(1, 4'd5, 32'h55, 0, 0,         1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd3);
      vecs[9]  = mkv(0, 4'd0, 32'h0, 0, 0,          0, 1, 0, 4'd0, 32'h0, 4'd5, 4'd3);
      vecs[10] = mkv(0, 4'd0, 32'h0, 0, 0,          1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd4);
      vecs[11] = mkv(1, 4'd6, 32'h66, 1, 1,         1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd4);
      vecs[12] = mkv(1, 4'd7, 32'h77, 1, 1,         0, 1, 1, 4'd6, 32'h66, 4'd6, 4'd4);
      vecs[13] = mkv(0, 4'd0, 32'h0, 0, 1,          0, 1, 1, 4'd7, 32'h77, 4'd7, 4'd5);
      vecs[14] = mkv(0, 4'd0, 32'h0, 0, 1,          1, 1, 0, 4'd0, 32'h0, 4'd0, 4'd6);

      // Reset state
      #1;
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_rt", 32'(rt), 32'd0);
      check("rst_opcode", 32'(opcode), 32'(NOP_OP));
      check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
      do_reset();

      // Table: single write, backpressure/full, non-writer retire, push+pop
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].in_valid, vecs[i].rd, vecs[i].data, vecs[i].wb_en, vecs[i].rf_ready,
               1'b0);
         #1;
         check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
         check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
         check($sformatf("v%0d_rt", i), 32'(rt), 32'(vecs[i].e_rt));
         check($sformatf("v%0d_opcode", i), 32'(opcode),
               32'(vecs[i].e_empty ? NOP_OP : ALU_OP));
         check($sformatf("v%0d_retire_cnt", i), 32'(retire_cnt), 32'(vecs[i].e_cnt));
         if (vecs[i].e_we) begin
            check($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
            check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
         end
         tick();
      end

      // Flush with two entries queued and a push offered
      drive(1'b1, 4'd8, 32'h88, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'd9, 32'h99, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("fl_full", 32'(in_ready), 32'd0);
`ifdef WB_FORWARD_EN
      check("fwd_valid", 32'(fwd_valid), 32'd1);
      check("fwd_reg", 32'(fwd_reg), 32'd8);
      check("fwd_data", fwd_data, 32'h88);
`endif
      drive(1'b1, 4'd10, 32'hAA, 1'b1, 1'b1, 1'b1);
      #1;
      check("fl_rf_we", 32'(rf_we), 32'd0);
`ifdef WB_FORWARD_EN
      check("fl_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
      tick();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("fl_empty", 32'(empty), 32'd1);
      check("fl_rf_we_after", 32'(rf_we), 32'd0);
      check("fl_retire_cnt", 32'(retire_cnt), 32'd6);
      tick();
      check("fl_no_push", 32'(empty), 32'd1);

      // 17 retirements from reset wrap a 4-bit counter to 1
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 4'(i), 32'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      check("wrap_retire_cnt", 32'(retire_cnt), 32'd1);
      check("wrap_empty", 32'(empty), 32'd1);

      // Asynchronous reset mid-operation
      drive(1'b1, 4'd11, 32'hBB, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'd12, 32'hCC, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("mid_rf_we_pre", 32'(rf_we), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_empty", 32'(empty), 32'd1);
      check("mid_in_ready", 32'(in_ready), 32'd1);
      check("mid_rf_we", 32'(rf_we), 32'd0);
      check("mid_rt", 32'(rt), 32'd0);
      check("mid_retire_cnt", 32'(retire_cnt), 32'd0);
      tick();
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
